register_mem: RTL and testbench
===============================

REGISTER_MEM -- requirements
Module: register_mem

Interface
REQ-001 Parameter: DATA_W, default 32, register and data-bus width; all widths below assume the default.
REQ-002 Parameter: ADDR_W, default 4, address width; register count is 2**ADDR_W = 16.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 DirA  in  4  read address for port A.
REQ-007 DirB  in  4  read address for port B.
REQ-008 Dir_WRA  in  4  write address.
REQ-009 DI  in  32  write data.
REQ-010 RE_A  in  1  port-A read enable, active-low.
REQ-011 RE_B  in  1  port-B read enable, active-low.
REQ-012 reg_WE  in  1  write enable, active-low.
REQ-013 DataA  out  32  port-A read data.
REQ-014 DataB  out  32  port-B read data.
REQ-015 Reg_0, Reg_1, Reg_2  out  32 each  continuous taps of registers 0, 1 and 2.

Function
REQ-016 Storage SHALL be 16 x 32-bit registers, addresses 0-15; all are writable, including register 0.
REQ-017 On a rising clk edge with reg_WE=0 and rst=0, register[Dir_WRA] SHALL load DI; all other registers SHALL hold.
REQ-018 With reg_WE=1, no register SHALL change.
REQ-019 DataA SHALL be combinational: register[DirA] when RE_A=0, otherwise 32'h0.
REQ-020 DataB SHALL be combinational: register[DirB] when RE_B=0, otherwise 32'h0.
REQ-021 Both read ports SHALL operate independently and simultaneously; DirA equal to DirB is legal and returns the same value on both ports.
REQ-022 Read during a write to the same address SHALL return the old value until the write edge, then the new value with zero further latency; there is no write-through bypass before the edge.
REQ-023 Reg_0, Reg_1 and Reg_2 SHALL always reflect registers 0, 1 and 2, independent of RE_A, RE_B and the read addresses.
REQ-024 Write-to-read latency: a value written at edge N SHALL be visible on enabled read ports and on the taps immediately after edge N.
REQ-025 There SHALL be no address wrap or out-of-range case; every 4-bit address is valid.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, clear all 16 registers to 0.
REQ-027 While rst=1, writes SHALL be ignored and Reg_0, Reg_1, Reg_2 SHALL read 0.
REQ-028 While rst=1, DataA and DataB SHALL read 0 whether or not their ports are enabled.
REQ-029 Asserting rst mid-operation SHALL discard any write pending in that cycle.
REQ-030 Writes SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-031 Write/read: rst pulse; reg_WE=0, Dir_WRA=1, DI=1 for one edge; then reg_WE=1, RE_A=0, DirA=1 -> DataA=1, Reg_1=1, Reg_0=0, Reg_2=0.
REQ-032 Read disable: registers 3=32'hDEADBEEF and 5=32'h12345678; RE_A=1, RE_B=0, DirB=5 -> DataA=0, DataB=32'h12345678; then RE_A=0, DirA=3 -> DataA=32'hDEADBEEF.
REQ-033 Write inhibit: reg_WE=1, Dir_WRA=2, DI=7 over several edges -> Reg_2 stays 0.
REQ-034 Same-address read during write: reg 4=9; RE_A=0, DirA=4, reg_WE=0, DI=10 -> DataA=9 before the edge, 10 after it.
REQ-035 Async reset: write 32'hFFFFFFFF to registers 0-15; assert rst between clock edges -> all taps and enabled read ports read 0 before the next edge.
REQ-036 Sweep: write value (addr+100) to every address 0-15; read each address back on both ports -> each port returns addr+100.

Source files
------------

// File: rtl/register_mem.sv
// 16-entry register file with one write port, two independent combinational
// read ports and fixed taps of registers 0-2. Asynchronous active-high reset.
module register_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] DirA,
    input  logic [ADDR_W-1:0] DirB,
    input  logic [ADDR_W-1:0] Dir_WRA,
    input  logic [DATA_W-1:0] DI,
    input  logic              RE_A,
    input  logic              RE_B,
    input  logic              reg_WE,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] Reg_0,
    output logic [DATA_W-1:0] Reg_1,
    output logic [DATA_W-1:0] Reg_2
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next-state: only the addressed register takes DI when the active-low enable is low
    always_comb begin
        regs_d = regs_q;
        if (!reg_WE) begin
            regs_d[Dir_WRA] = DI;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports are gated by rst too, so they are zero for the whole reset window
    assign DataA = (!rst && !RE_A) ? regs_q[DirA] : '0;
    assign DataB = (!rst && !RE_B) ? regs_q[DirB] : '0;

    assign Reg_0 = regs_q[0];
    assign Reg_1 = regs_q[1];
    assign Reg_2 = regs_q[2];

endmodule

// File: tb/tb_register_mem.sv
// Self-checking bench for register_mem: directed scenarios plus a randomized
// run checked against an array model of the register file.
module tb_register_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  DirA, DirB, Dir_WRA;
    logic [31:0] DI;
    logic        RE_A, RE_B, reg_WE;
    logic [31:0] DataA, DataB, Reg_0, Reg_1, Reg_2;

    logic [31:0] model [16];
    int n_checks = 0;
    int n_fail   = 0;

    register_mem dut (
        .clk     (clk),
        .rst     (rst),
        .DirA    (DirA),
        .DirB    (DirB),
        .Dir_WRA (Dir_WRA),
        .DI      (DI),
        .RE_A    (RE_A),
        .RE_B    (RE_B),
        .reg_WE  (reg_WE),
        .DataA   (DataA),
        .DataB   (DataB),
        .Reg_0   (Reg_0),
        .Reg_1   (Reg_1),
        .Reg_2   (Reg_2)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // One write on the next rising edge; model updated after the edge
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        Dir_WRA = a;
        DI      = d;
        reg_WE  = 1'b0;
        @(posedge clk);
        #1;
        reg_WE = 1'b1;
        model[a] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_WE = 1'b1; RE_A = 1'b0; RE_B = 1'b0;
        DirA = 4'd0; DirB = 4'd1; Dir_WRA = 4'd0; DI = 32'h0;
        clear_model();
        #1;
        n_checks++;
        if (Reg_0 !== 32'h0 || Reg_1 !== 32'h0 || Reg_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_taps: got %h %h %h, expected all 0", Reg_0, Reg_1, Reg_2);
        end
        n_checks++;
        if (DataA !== 32'h0 || DataB !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ports: got A=%h B=%h, expected 0", DataA, DataB);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        pulse_reset();
        do_write(4'd1, 32'd1);
        RE_A = 1'b0; DirA = 4'd1;
        #1;
        n_checks++;
        if (DataA !== 32'd1) begin
            n_fail++;
            $display("FAIL write_read_DataA: got %h expected %h", DataA, 32'd1);
        end
        n_checks++;
        if (Reg_1 !== 32'd1 || Reg_0 !== 32'h0 || Reg_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL write_read_taps: got %h %h %h expected 0 1 0", Reg_0, Reg_1, Reg_2);
        end
    endtask

    task automatic test_read_disable();
        do_write(4'd3, 32'hDEADBEEF);
        do_write(4'd5, 32'h12345678);
        RE_A = 1'b1; RE_B = 1'b0; DirA = 4'd3; DirB = 4'd5;
        #1;
        n_checks++;
        if (DataA !== 32'h0) begin
            n_fail++;
            $display("FAIL read_disable_A: got %h expected 0", DataA);
        end
        n_checks++;
        if (DataB !== 32'h12345678) begin
            n_fail++;
            $display("FAIL read_enable_B: got %h expected 12345678", DataB);
        end
        RE_A = 1'b0;
        #1;
        n_checks++;
        if (DataA !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_enable_A: got %h expected deadbeef", DataA);
        end
        RE_B = 1'b1;
        #1;
        n_checks++;
        if (DataB !== 32'h0) begin
            n_fail++;
            $display("FAIL read_disable_B: got %h expected 0", DataB);
        end
    endtask

    task automatic test_write_inhibit();
        @(negedge clk);
        reg_WE = 1'b1; Dir_WRA = 4'd2; DI = 32'd7;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (Reg_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL write_inhibit: got %h expected 0", Reg_2);
        end
    endtask

    task automatic test_same_addr();
        do_write(4'd4, 32'd9);
        @(negedge clk);
        RE_A = 1'b0; DirA = 4'd4; Dir_WRA = 4'd4; DI = 32'd10; reg_WE = 1'b0;
        #1;
        n_checks++;
        if (DataA !== 32'd9) begin
            n_fail++;
            $display("FAIL same_addr_before_edge: got %h expected %h", DataA, 32'd9);
        end
        @(posedge clk);
        #1;
        reg_WE = 1'b1;
        model[4] = 32'd10;
        n_checks++;
        if (DataA !== 32'd10) begin
            n_fail++;
            $display("FAIL same_addr_after_edge: got %h expected %h", DataA, 32'd10);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) do_write(4'(i), 32'hFFFFFFFF);
        RE_A = 1'b0; RE_B = 1'b0; DirA = 4'd7; DirB = 4'd15;
        // Pending write that the reset must swallow
        @(negedge clk);
        Dir_WRA = 4'd6; DI = 32'h55; reg_WE = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (Reg_0 !== 32'h0 || Reg_1 !== 32'h0 || Reg_2 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_taps: got %h %h %h expected 0", Reg_0, Reg_1, Reg_2);
        end
        n_checks++;
        if (DataA !== 32'h0 || DataB !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_ports: got A=%h B=%h expected 0", DataA, DataB);
        end
        @(posedge clk);
        @(negedge clk);
        clear_model();
        DirA = 4'd6;
        rst = 1'b0;
        reg_WE = 1'b1;
        #1;
        n_checks++;
        if (DataA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_discards_write: got %h expected 0", DataA);
        end
        do_write(4'd0, 32'hA5A5_0001);
        #1;
        n_checks++;
        if (Reg_0 !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL write_after_reset: got %h expected a5a50001", Reg_0);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) do_write(4'(i), 32'(i + 100));
        RE_A = 1'b0; RE_B = 1'b0;
        for (int i = 0; i < 16; i++) begin
            DirA = 4'(i); DirB = 4'(i);
            #1;
            n_checks++;
            if (DataA !== 32'(i + 100) || DataB !== 32'(i + 100)) begin
                n_fail++;
                $display("FAIL sweep addr %0d: got A=%0d B=%0d expected %0d", i, DataA, DataB, i + 100);
            end
        end
        DirA = 4'd9; DirB = 4'd2;
        #1;
        n_checks++;
        if (DataA !== 32'd109 || DataB !== 32'd102) begin
            n_fail++;
            $display("FAIL sweep_dual_addr: got A=%0d B=%0d expected 109 102", DataA, DataB);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            DirA    = 4'($urandom_range(0, 15));
            DirB    = 4'($urandom_range(0, 15));
            Dir_WRA = 4'($urandom_range(0, 15));
            DI      = $urandom;
            RE_A    = 1'($urandom_range(0, 3) == 0);
            RE_B    = 1'($urandom_range(0, 3) == 0);
            reg_WE  = 1'($urandom_range(0, 1));
            #1;
            exp_a = RE_A ? 32'h0 : model[DirA];
            exp_b = RE_B ? 32'h0 : model[DirB];
            n_checks++;
            if (DataA !== exp_a || DataB !== exp_b) begin
                n_fail++;
                $display("FAIL random_ports iter %0d: got A=%h B=%h expected A=%h B=%h", n, DataA, DataB, exp_a, exp_b);
            end
            n_checks++;
            if (Reg_0 !== model[0] || Reg_1 !== model[1] || Reg_2 !== model[2]) begin
                n_fail++;
                $display("FAIL random_taps iter %0d: got %h %h %h expected %h %h %h", n, Reg_0, Reg_1, Reg_2, model[0], model[1], model[2]);
            end
            @(posedge clk);
            if (!reg_WE) model[Dir_WRA] = DI;
        end
        @(negedge clk);
        reg_WE = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_disable();
        test_write_inhibit();
        test_same_addr();
        test_async_reset();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
